instr_fetch: RTL and testbench

//  Instruction-fetch stage directly upstream of the bit-serial decoder.

---
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage feeding the bit-serial decoder
module instr_fetch #(
    parameter int ADDR_W = 4,
    parameter bit LOOP   = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_prog_en,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [2:0]        i_prog_data,
    input  logic [ADDR_W-1:0] i_last_addr,
    input  logic              i_run,
    input  logic              i_pcincr,
    input  logic [2:0]        i_count,
    output logic [2:0]        o_instr,
    output logic [2:0]        o_data_count,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_running,
    output logic              o_halted
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PROG = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    logic [1:0]        state;
    logic [2:0]        mem [0:DEPTH-1];
    logic [ADDR_W-1:0] pc_next;

    assign pc_next = o_pc + PC_ONE;

    // Program memory is intentionally left out of reset; writes only land while in PROG
    always_ff @(posedge i_clk) begin
        if (!i_rst && state == ST_PROG && i_prog_we) begin
            mem[i_prog_addr] <= i_prog_data;
        end
    end

    // Control FSM; PC and opcode register always change in the same cycle so there is no bubble
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            o_pc    <= '0;
            o_instr <= 3'b000;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (i_prog_en) begin
                        state   <= ST_PROG;
                        o_pc    <= '0;
                        o_instr <= 3'b000;
                    end else if (i_run) begin
                        state   <= ST_RUN;
                        o_pc    <= '0;
                        o_instr <= mem[0];
                    end
                end
                ST_PROG: begin
                    o_pc    <= '0;
                    o_instr <= 3'b000;
                    if (!i_prog_en) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (i_prog_en) begin
                        state   <= ST_PROG;
                        o_pc    <= '0;
                        o_instr <= 3'b000;
                    end else if (i_pcincr) begin
                        if (o_pc != i_last_addr) begin
                            o_pc    <= pc_next;
                            o_instr <= mem[pc_next];
                        end else if (LOOP) begin
                            o_pc    <= '0;
                            o_instr <= mem[0];
                        end else begin
                            state   <= ST_HALT;
                            o_instr <= 3'b000;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_pc    <= '0;
                    o_instr <= 3'b000;
                end
            endcase
        end
    end

    assign o_running = (state == ST_RUN);
    assign o_halted  = (state == ST_HALT);

    // Closes the decoder bit-counter loop; held at zero outside RUN so the decoder restarts cleanly
    always_comb begin
        o_data_count = 3'd0;
        if (o_running) begin
            o_data_count = i_count + 3'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch in halting and looping builds
module tb_instr_fetch;

    logic       clk;
    logic       rst;
    logic       prog_en;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [2:0] prog_data;
    logic [3:0] last_addr;
    logic       run;
    logic       pcincr;
    logic [2:0] count;

    logic [2:0] h_instr, l_instr;
    logic [2:0] h_dc, l_dc;
    logic [3:0] h_pc, l_pc;
    logic       h_running, l_running;
    logic       h_halted, l_halted;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(.ADDR_W(4), .LOOP(1'b0)) u_halt (
        .i_clk(clk), .i_rst(rst), .i_prog_en(prog_en), .i_prog_we(prog_we),
        .i_prog_addr(prog_addr), .i_prog_data(prog_data), .i_last_addr(last_addr),
        .i_run(run), .i_pcincr(pcincr), .i_count(count),
        .o_instr(h_instr), .o_data_count(h_dc), .o_pc(h_pc),
        .o_running(h_running), .o_halted(h_halted)
    );

    instr_fetch #(.ADDR_W(4), .LOOP(1'b1)) u_loop (
        .i_clk(clk), .i_rst(rst), .i_prog_en(prog_en), .i_prog_we(prog_we),
        .i_prog_addr(prog_addr), .i_prog_data(prog_data), .i_last_addr(last_addr),
        .i_run(run), .i_pcincr(pcincr), .i_count(count),
        .o_instr(l_instr), .o_data_count(l_dc), .o_pc(l_pc),
        .o_running(l_running), .o_halted(l_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_h(input string tag, input logic [2:0] instr, input logic [3:0] pc,
                           input logic running, input logic halted);
        check({tag, "_h_instr"}, 32'(h_instr), 32'(instr));
        check({tag, "_h_pc"}, 32'(h_pc), 32'(pc));
        check({tag, "_h_running"}, 32'(h_running), 32'(running));
        check({tag, "_h_halted"}, 32'(h_halted), 32'(halted));
    endtask

    task automatic check_l(input string tag, input logic [2:0] instr, input logic [3:0] pc,
                           input logic running, input logic halted);
        check({tag, "_l_instr"}, 32'(l_instr), 32'(instr));
        check({tag, "_l_pc"}, 32'(l_pc), 32'(pc));
        check({tag, "_l_running"}, 32'(l_running), 32'(running));
        check({tag, "_l_halted"}, 32'(l_halted), 32'(halted));
    endtask

    logic [2:0] prog_tbl [4];
    logic [2:0] dc_tbl   [8];

    initial begin
        prog_tbl = '{3'b111, 3'b100, 3'b010, 3'b001};
        dc_tbl   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        rst = 1'b1; prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        last_addr = 4'd3; run = 1'b0; pcincr = 1'b0; count = 3'd5;
        tick();
        rst = 1'b0;

        // T1 reset state and ignored pcincr in IDLE
        check_h("t1_reset", 3'b000, 4'd0, 1'b0, 1'b0);
        check("t1_idle_dc", 32'(h_dc), 32'd0);
        pcincr = 1'b1;
        tick();
        tick();
        check_h("t1_idle_pcincr", 3'b000, 4'd0, 1'b0, 1'b0);
        pcincr = 1'b0;

        // T2 program four opcodes then run
        prog_en = 1'b1;
        tick();
        prog_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prog_addr = 4'(i);
            prog_data = prog_tbl[i];
            tick();
            check_h("t2_prog_hold", 3'b000, 4'd0, 1'b0, 1'b0);
        end
        prog_we = 1'b0;
        prog_en = 1'b0;
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        check_h("t2_run0", 3'b111, 4'd0, 1'b1, 1'b0);
        check_l("t2_run0", 3'b111, 4'd0, 1'b1, 1'b0);
        pcincr = 1'b1;
        tick();
        check_h("t2_pc1", 3'b100, 4'd1, 1'b1, 1'b0);
        tick();
        check_h("t2_pc2", 3'b010, 4'd2, 1'b1, 1'b0);
        tick();
        check_h("t2_pc3", 3'b001, 4'd3, 1'b1, 1'b0);
        check_l("t2_pc3", 3'b001, 4'd3, 1'b1, 1'b0);

        // T3 / T4 end of program: halt vs wrap
        tick();
        pcincr = 1'b0;
        check_h("t3_halt", 3'b000, 4'd3, 1'b0, 1'b1);
        check_l("t4_wrap", 3'b111, 4'd0, 1'b1, 1'b0);

        // T6 counter loop in RUN and outside RUN
        for (int i = 0; i < 8; i++) begin
            count = 3'(i);
            #1;
            check("t6_run_dc", 32'(l_dc), 32'(dc_tbl[i]));
            check("t6_halt_dc", 32'(h_dc), 32'd0);
        end

        // T3 restart from HALT; run ignored in RUN
        run = 1'b1;
        tick();
        run = 1'b0;
        check_h("t3_restart", 3'b111, 4'd0, 1'b1, 1'b0);
        check_l("t3_run_ignored", 3'b111, 4'd0, 1'b1, 1'b0);

        // T5 write attempt in RUN, then abort at pc=2
        pcincr = 1'b1;
        tick();
        tick();
        pcincr = 1'b0;
        check_h("t5_pc2", 3'b010, 4'd2, 1'b1, 1'b0);
        prog_we = 1'b1; prog_addr = 4'd3; prog_data = 3'b101;
        tick();
        check_h("t5_we_in_run", 3'b010, 4'd2, 1'b1, 1'b0);
        prog_we = 1'b0;
        prog_en = 1'b1; pcincr = 1'b1;
        tick();
        check_h("t5_abort", 3'b000, 4'd0, 1'b0, 1'b0);
        check_l("t5_abort", 3'b000, 4'd0, 1'b0, 1'b0);
        prog_en = 1'b0; pcincr = 1'b0;
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        pcincr = 1'b1;
        tick();
        tick();
        tick();
        pcincr = 1'b0;
        check_h("t5_mem_intact", 3'b001, 4'd3, 1'b1, 1'b0);

        // T6 synchronous reset mid-RUN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_h("t6_rst_run", 3'b000, 4'd0, 1'b0, 1'b0);
        check("t6_rst_dc", 32'(h_dc), 32'd0);

        // one-instruction program
        last_addr = 4'd0;
        run = 1'b1;
        tick();
        run = 1'b0;
        pcincr = 1'b1;
        tick();
        pcincr = 1'b0;
        check_h("one_instr_halt", 3'b000, 4'd0, 1'b0, 1'b1);
        check_l("one_instr_wrap", 3'b111, 4'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
